// File: rtl/river_carry_engine_pkg.sv
// -----------------------------------------------------------------------------
// river_pkg
// Shared types and defaults for the river carry resolver.
//   state_t      : resolver FSM states (IDLE, SCAN, APPLY)
//   *_DEF        : default playfield geometry
//   row_y()      : top-edge y coordinate of river row r
// -----------------------------------------------------------------------------
package river_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam int TILE_DEF     = 32;
    localparam int ROW_Y0_DEF   = 64;
    localparam int SCREEN_W_DEF = 320;
    localparam int FROG_W_DEF   = 32;

    // y of river row r; rows are stacked downward from row 0 at one tile pitch
    function automatic int row_y(input int r, input int y0, input int tile);
        return y0 + r * tile;
    endfunction

endpackage

// File: rtl/river_carry_engine_log_hit_test.sv
// -----------------------------------------------------------------------------
// log_hit_test
// Combinational test of the frog centre against one log, including logs that
// run off the right edge and reappear at x = 0.
//   i_cx      : frog centre x (one bit wider than a coordinate)
//   i_log_x   : log left edge
//   i_log_len : log length, 0 = empty slot (never hits)
//   o_hit     : centre lies on the log
// -----------------------------------------------------------------------------
module log_hit_test #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 320
) (
    input  logic [COORD_W:0]   i_cx,
    input  logic [COORD_W-1:0] i_log_x,
    input  logic [COORD_W-1:0] i_log_len,
    output logic               o_hit
);

    localparam logic [COORD_W:0] SCREEN_W_C = (COORD_W+1)'(SCREEN_W);

    logic [COORD_W:0] w_end;
    logic [COORD_W:0] w_wrap_end;
    logic             w_main;
    logic             w_tail;

    assign w_end      = {1'b0, i_log_x} + {1'b0, i_log_len};
    assign w_wrap_end = w_end - SCREEN_W_C;

    // Main span is half-open [x, x+len)
    assign w_main = (i_cx >= {1'b0, i_log_x}) && (i_cx < w_end);
    // Portion past the screen edge reappears as [0, x+len-SCREEN_W)
    assign w_tail = (w_end > SCREEN_W_C) && (i_cx < w_wrap_end);

    assign o_hit = (i_log_len != '0) && (w_main || w_tail);

endmodule

// File: rtl/river_carry_engine.sv
// -----------------------------------------------------------------------------
// river_carry_engine
// Per-frame river resolver. A frame tick latches the frog position and the log
// table; if the frog sits on a river row, that row's logs are scanned one slot
// per cycle and the frog is carried, drowned, or swept off a screen edge.
//   clk, reset       : clock, synchronous active-high reset
//   frame_tick       : starts a resolve (ignored and flagged while busy)
//   frog_x, frog_y   : frog top-left position
//   log_x, log_len   : packed log table, slot (r,k) at (r*NUM_LOGS+k)*COORD_W
//   row_speed        : packed per-row speed magnitude
//   row_dir          : per-row direction, 1 = left
//   frog_x_new       : resolved frog x
//   frog_on_log      : carried this frame
//   frog_in_water    : on a river row with no log under the frog
//   frog_swept_off   : carry clamped at a screen edge
//   carry_log        : slot that carried the frog
//   result_valid     : one-cycle pulse, outputs just updated
//   busy             : resolve in progress
//   tick_overrun     : sticky, a tick arrived while busy
// -----------------------------------------------------------------------------
module river_carry_engine
    import river_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int NUM_LOGS = 3,
    parameter int COORD_W  = 10,
    parameter int SPEED_W  = 4,
    parameter int TILE     = TILE_DEF,
    parameter int ROW_Y0   = ROW_Y0_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int FROG_W   = FROG_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic [COORD_W-1:0]                    frog_x,
    input  logic [COORD_W-1:0]                    frog_y,
    input  logic [NUM_ROWS*NUM_LOGS*COORD_W-1:0]  log_x,
    input  logic [NUM_ROWS*NUM_LOGS*COORD_W-1:0]  log_len,
    input  logic [NUM_ROWS*SPEED_W-1:0]           row_speed,
    input  logic [NUM_ROWS-1:0]                   row_dir,
    output logic [COORD_W-1:0]                    frog_x_new,
    output logic                                  frog_on_log,
    output logic                                  frog_in_water,
    output logic                                  frog_swept_off,
    output logic [$clog2(NUM_LOGS)-1:0]           carry_log,
    output logic                                  result_valid,
    output logic                                  busy,
    output logic                                  tick_overrun
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int K_W   = $clog2(NUM_LOGS);

    localparam logic [K_W-1:0]            K_LAST  = K_W'(NUM_LOGS - 1);
    localparam logic signed [COORD_W+1:0] X_MAX_S = (COORD_W+2)'(SCREEN_W - FROG_W);
    localparam logic [COORD_W-1:0]        X_MAX   = COORD_W'(SCREEN_W - FROG_W);

    state_t r_state, w_next;

    // Snapshot of the frame's inputs
    logic [COORD_W-1:0]                   r_frog_x;
    logic [NUM_ROWS*NUM_LOGS*COORD_W-1:0] r_log_x;
    logic [NUM_ROWS*NUM_LOGS*COORD_W-1:0] r_log_len;
    logic [NUM_ROWS*SPEED_W-1:0]          r_row_speed;
    logic [NUM_ROWS-1:0]                  r_row_dir;

    // Resolve context
    logic [ROW_W-1:0] r_row;
    logic             r_row_valid;
    logic [K_W-1:0]   r_k;
    logic             r_hit;
    logic [K_W-1:0]   r_hit_k;

    logic                      w_row_found;
    logic [ROW_W-1:0]          w_row_idx;
    logic [COORD_W-1:0]        w_sel_x;
    logic [COORD_W-1:0]        w_sel_len;
    logic [COORD_W:0]          w_cx;
    logic                      w_hit;
    logic [SPEED_W-1:0]        w_speed;
    logic                      w_dir;
    logic signed [COORD_W+1:0] w_fx_s;
    logic signed [COORD_W+1:0] w_sp_s;
    logic signed [COORD_W+1:0] w_nx;
    logic [COORD_W-1:0]        w_x_new;
    logic                      w_on_log;
    logic                      w_in_water;
    logic                      w_swept;
    logic [K_W-1:0]            w_carry;

    // ---------------- FSM ----------------
    // NOTE: state is clocked with non-blocking assignments so every register
    // in the design samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of a combinational block gets a default first; any
    // path that left one unassigned would infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick) w_next = w_row_found ? SCAN : APPLY;
            SCAN:    if (w_hit || (r_k == K_LAST)) w_next = APPLY;
            APPLY:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Which river row (if any) the frog's top edge sits on
    always_comb begin
        w_row_found = 1'b0;
        w_row_idx   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!w_row_found && (int'(frog_y) == row_y(r, ROW_Y0, TILE))) begin
                w_row_found = 1'b1;
                w_row_idx   = ROW_W'(r);
            end
        end
    end

    // ---------------- Shared slot test ----------------
    assign w_sel_x   = r_log_x  [(int'(r_row) * NUM_LOGS + int'(r_k)) * COORD_W +: COORD_W];
    assign w_sel_len = r_log_len[(int'(r_row) * NUM_LOGS + int'(r_k)) * COORD_W +: COORD_W];
    assign w_cx      = {1'b0, r_frog_x} + (COORD_W+1)'(FROG_W / 2);

    log_hit_test #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W)
    ) u_hit (
        .i_cx      (w_cx),
        .i_log_x   (w_sel_x),
        .i_log_len (w_sel_len),
        .o_hit     (w_hit)
    );

    // ---------------- Carry arithmetic ----------------
    assign w_speed = r_row_speed[int'(r_row) * SPEED_W +: SPEED_W];
    assign w_dir   = r_row_dir[r_row];
    assign w_fx_s  = $signed({2'b00, r_frog_x});
    assign w_sp_s  = $signed({{(COORD_W+2-SPEED_W){1'b0}}, w_speed});
    assign w_nx    = w_dir ? (w_fx_s - w_sp_s) : (w_fx_s + w_sp_s);

    always_comb begin
        w_x_new    = r_frog_x;
        w_on_log   = 1'b0;
        w_in_water = 1'b0;
        w_swept    = 1'b0;
        w_carry    = '0;
        if (r_row_valid) begin
            if (!r_hit) begin
                w_in_water = 1'b1;
            end else begin
                w_on_log = 1'b1;
                w_carry  = r_hit_k;
                if (w_nx < 0) begin
                    w_x_new = '0;
                    w_swept = 1'b1;
                end else if (w_nx > X_MAX_S) begin
                    w_x_new = X_MAX;
                    w_swept = 1'b1;
                end else begin
                    w_x_new = w_nx[COORD_W-1:0];
                end
            end
        end
    end

    // ---------------- Input snapshot ----------------
    // NOTE: the snapshot is deliberately left out of reset; it is always
    // rewritten on the tick that starts a resolve before anything reads it.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && frame_tick) begin
            r_frog_x    <= frog_x;
            r_log_x     <= log_x;
            r_log_len   <= log_len;
            r_row_speed <= row_speed;
            r_row_dir   <= row_dir;
        end
    end

    // ---------------- Control and outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row          <= '0;
            r_row_valid    <= 1'b0;
            r_k            <= '0;
            r_hit          <= 1'b0;
            r_hit_k        <= '0;
            frog_x_new     <= '0;
            frog_on_log    <= 1'b0;
            frog_in_water  <= 1'b0;
            frog_swept_off <= 1'b0;
            carry_log      <= '0;
            result_valid   <= 1'b0;
            tick_overrun   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (frame_tick && r_state != IDLE) tick_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (frame_tick) begin
                        r_row       <= w_row_idx;
                        r_row_valid <= w_row_found;
                        r_k         <= '0;
                        r_hit       <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_hit   <= 1'b1;
                        r_hit_k <= r_k;
                    end else if (r_k != K_LAST) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                APPLY: begin
                    frog_x_new     <= w_x_new;
                    frog_on_log    <= w_on_log;
                    frog_in_water  <= w_in_water;
                    frog_swept_off <= w_swept;
                    carry_log      <= w_carry;
                    result_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: doc/river_carry_engine.md
Name: river_carry_engine

Overview:
Per-frame river resolver for the frogger playfield. On each frame tick it latches the frog position and the log table, finds which river row the frog occupies, and scans that row's logs one per cycle. It then reports one of three results: carried (x moved by the row's signed speed), drowned, or swept off the screen edge. It sits between the log-motion generator and the frog/death controller, and generalises row count, log count, per-row speed/direction and screen wrap.

Parameters:
NUM_ROWS, 4, number of river rows
NUM_LOGS, 3, log slots per row
COORD_W, 10, coordinate width (pixels)
SPEED_W, 4, per-row speed magnitude width (pixels/frame)
TILE, 32, row pitch in pixels
ROW_Y0, 64, y of river row 0; row r at y = ROW_Y0 + r*TILE
SCREEN_W, 320, playfield width; log x coordinates wrap modulo SCREEN_W
FROG_W, 32, frog sprite width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame; starts a resolve
frog_x  in  COORD_W  frog left edge
frog_y  in  COORD_W  frog top edge
log_x  in  NUM_ROWS*NUM_LOGS*COORD_W  log left edges; slot (r,k) at bits [(r*NUM_LOGS+k)*COORD_W +: COORD_W]
log_len  in  NUM_ROWS*NUM_LOGS*COORD_W  log lengths, same packing; 0 = slot empty
row_speed  in  NUM_ROWS*SPEED_W  per-row speed magnitude
row_dir  in  NUM_ROWS  1 = moving left, 0 = moving right
frog_x_new  out  COORD_W  resolved frog x
frog_on_log  out  1  frog carried this frame
frog_in_water  out  1  frog in a river row with no log under it
frog_swept_off  out  1  carry pushed frog past a screen edge
carry_log  out  $clog2(NUM_LOGS)  slot index that carried the frog
result_valid  out  1  one-cycle pulse; outputs updated
busy  out  1  resolve in progress
tick_overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; tick_overrun cleared. Reset mid-resolve aborts it, and no result_valid is issued.
- FSM states:
  - IDLE: on frame_tick, latch all inputs.
    - If frog_y equals some row's y: save row index, set k=0, go to SCAN.
    - Otherwise go to APPLY with no row.
    - busy = 1 in every state except IDLE.
  - SCAN: test slot k each cycle.
    - On a hit: record k, go to APPLY.
    - Else if k = NUM_LOGS-1: go to APPLY with miss.
    - Else k++.
  - APPLY: register the outputs, pulse result_valid (visible the cycle after APPLY), return to IDLE.
- Hit test:
  - cx = frog_x + FROG_W/2.
  - Hit if log_len != 0 and cx is in [log_x, log_x+log_len).
  - If log_x+log_len > SCREEN_W (the log wraps), cx in [0, log_x+log_len-SCREEN_W) also hits.
  - Lowest slot index wins.
- APPLY results:
  - No row: x_new = frog_x, all flags 0.
  - Miss: frog_in_water = 1, x_new = frog_x.
  - Hit:
    - frog_on_log = 1, carry_log = k.
    - nx = frog_x ± speed, computed signed in COORD_W+2 bits; minus when row_dir = 1.
    - If nx < 0: x_new = 0, frog_swept_off = 1.
    - If nx > SCREEN_W-FROG_W: x_new = SCREEN_W-FROG_W, frog_swept_off = 1.
    - Otherwise x_new = nx.
    - Speed 0 on a hit: on_log = 1, x unchanged.
- Latency, counted in edges from the tick edge to the edge that raises result_valid:
  - No row: 2.
  - Hit on slot k: k+3.
  - Miss: NUM_LOGS+2.
  - The worst case must fit one frame.
- frame_tick while busy: ignored, and tick_overrun is set (sticky until reset). A tick in the same cycle result_valid is high is accepted, because the FSM is then in IDLE.
- Outputs hold their values between results.

Decomposition:
- Package river_pkg: state enum (IDLE, SCAN, APPLY), TILE/SCREEN_W/FROG_W defaults, and a function row_y(r).
- Sub-module log_hit_test: combinational cx-vs-log compare with wrap handling. It is instantiated once and shared by the SCAN cycles.

Test Plan:
1. Carry right, slot 0: frog_y=96, frog_x=120; log(1,0) x=100 len=96; speed 2, dir 0 -> x_new=122, on_log=1, carry_log=0, valid 3 edges after tick.
2. Drown: frog_y=96, frog_x=220; row 1 logs at x=0/40 len=32 and one empty slot -> in_water=1, x_new=220, valid at edge 5.
3. Wrap and sweep-off: log(2,0) x=280 len=96; frog_y=128, frog_x=0; speed 3, dir 1 -> on_log=1, swept_off=1, x_new=0.
4. Not in river: frog_y=32, frog_x=50 -> all flags 0, x_new=50, valid at edge 2.
5. Priority: row 0 slots 1 and 2 both cover the frog, slot 0 empty -> carry_log=1, valid at edge 4.
6. Control: tick during SCAN -> ignored, tick_overrun=1. Reset asserted mid-SCAN -> all outputs 0, busy=0, no valid pulse, next tick resolves normally.
